// File: rtl/lc3_arb_pkg.sv
// lc3_arb_pkg: shared types and constants for the LC-3 memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ACCESS)
//   arb_owner_t : which requester owns the memory port (OWN_IF, OWN_D)
//   CNT_W       : width of the per-access wait counter
// Optional feature macro used by the arbiter files: LC3_ARB_RR_EN.
package lc3_arb_pkg;
  typedef enum logic {IDLE, ACCESS} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
  localparam int unsigned CNT_W = 3;
endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// lc3_mem_arbiter_if: bundle of the two requester handshakes and the
// shared memory port.
//   master : core/memory environment (drives requests and mem_rdata)
//   slave  : the arbiter (drives grants, read responses and mem_* outputs)
interface lc3_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lc3_arb_pick.sv
// lc3_arb_pick: combinational winner selection between fetch and data.
//   if_req, d_req : pending requests
//   last_owner    : most recent winner (only with LC3_ARB_RR_EN)
//   gnt           : one-hot winner, gnt[0] = IF, gnt[1] = D
// Default build: data always beats fetch. With LC3_ARB_RR_EN defined a tie
// goes to the requester that did not win most recently.
module lc3_arb_pick
  import lc3_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
`ifdef LC3_ARB_RR_EN
  input  arb_owner_t last_owner,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (d_req && if_req) begin
`ifdef LC3_ARB_RR_EN
      if (last_owner == OWN_D) gnt = 2'b01;
      else                     gnt = 2'b10;
`else
      gnt = 2'b10;
`endif
    end else if (d_req) begin
      gnt = 2'b10;
    end else if (if_req) begin
      gnt = 2'b01;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single LC-3 memory port between instruction
// fetch (IF) and load/store (D). One access at a time; the port is held for
// MEM_LAT cycles, then the owner receives an rvalid pulse with read data
// (0 for a store acknowledge).
//   clk   : system clock (posedge)
//   reset : synchronous, active-low
//   bus   : lc3_mem_arbiter_if.slave (requests, grants, responses, mem port)
// Optional feature: LC3_ARB_RR_EN selects round-robin tie-breaking.
module lc3_mem_arbiter
  import lc3_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  lc3_mem_arbiter_if.slave  bus
);

  arb_state_t        state, state_nxt;
  arb_owner_t        owner;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pick_gnt;
  logic              gnt_if, gnt_d;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] if_rdata, d_rdata;
  logic              if_rvalid, d_rvalid;
`ifdef LC3_ARB_RR_EN
  arb_owner_t        last_owner;
`endif

  lc3_arb_pick u_pick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
`ifdef LC3_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .gnt        (pick_gnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grants are only offered from IDLE and are suppressed during reset.
  always_comb begin
    state_nxt = state;
    gnt_if    = 1'b0;
    gnt_d     = 1'b0;
    case (state)
      IDLE: begin
        if (reset) begin
          gnt_if = pick_gnt[0];
          gnt_d  = pick_gnt[1];
          if (|pick_gnt) state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner     <= OWN_IF;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
`ifdef LC3_ARB_RR_EN
      last_owner <= OWN_IF;
`endif
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_d) begin
            mem_addr  <= bus.d_addr;
            mem_wdata <= bus.d_wdata;
            mem_we    <= bus.d_we;
            owner     <= OWN_D;
            cnt       <= CNT_W'(MEM_LAT - 1);
`ifdef LC3_ARB_RR_EN
            last_owner <= OWN_D;
`endif
          end else if (gnt_if) begin
            mem_addr  <= bus.if_addr;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            owner     <= OWN_IF;
            cnt       <= CNT_W'(MEM_LAT - 1);
`ifdef LC3_ARB_RR_EN
            last_owner <= OWN_IF;
`endif
          end else begin
            mem_we <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_we <= 1'b0;
            // mem_we is still held here, so it identifies a store ack.
            if (owner == OWN_D) begin
              d_rdata  <= mem_we ? '0 : bus.mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= bus.mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: scoreboard bench for lc3_mem_arbiter (MEM_LAT = 2).
// Granted requests push their expected response (data and arrival cycle)
// into per-requester queues; a negedge monitor pops and compares whenever
// an rvalid appears. A small memory model indexed by addr[14:12] supplies
// mem_rdata and absorbs stores.
module tb_lc3_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [8];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
      mem[3] <= 16'h1234;
      mem[5] <= 16'hA5A5;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[14:12]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[14:12]];

  typedef struct {
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;
  exp_t q_if[$];
  exp_t q_d[$];
  exp_t e_if, e_d;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (bus.if_rvalid === 1'b1) begin
      if (q_if.size() == 0) check("if_rvalid_unexpected", {31'd0, bus.if_rvalid}, 32'd0);
      else begin
        e_if = q_if.pop_front();
        check("if_rdata", {16'd0, bus.if_rdata}, {16'd0, e_if.data});
        check("if_rvalid_cycle", cyc, e_if.cyc);
      end
    end else if (q_if.size() != 0 && cyc >= q_if[0].cyc) begin
      check("if_rvalid_missing", {31'd0, bus.if_rvalid}, 32'd1);
      void'(q_if.pop_front());
    end
    if (bus.d_rvalid === 1'b1) begin
      if (q_d.size() == 0) check("d_rvalid_unexpected", {31'd0, bus.d_rvalid}, 32'd0);
      else begin
        e_d = q_d.pop_front();
        check("d_rdata", {16'd0, bus.d_rdata}, {16'd0, e_d.data});
        check("d_rvalid_cycle", cyc, e_d.cyc);
      end
    end else if (q_d.size() != 0 && cyc >= q_d[0].cyc) begin
      check("d_rvalid_missing", {31'd0, bus.d_rvalid}, 32'd1);
      void'(q_d.pop_front());
    end
  end

  // Single access: wait (bounded) for grant, then check the held port.
  task automatic do_req(input bit is_d, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rexp);
    bit got;
    exp_t e;
    got = 1'b0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((is_d ? bus.d_gnt : bus.if_gnt) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(is_d ? "d_gnt_seen" : "if_gnt_seen", {31'd0, got}, 32'd1);
    e.data = rexp;
    e.cyc  = cyc + 3;
    if (got) begin
      if (is_d) q_d.push_back(e);
      else      q_if.push_back(e);
    end
    @(posedge clk); #1;
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      check("mem_addr_held", {16'd0, bus.mem_addr}, {16'd0, addr});
      check("mem_we_held", {31'd0, bus.mem_we}, {31'd0, is_d & we});
      check("mem_wdata_held", {16'd0, bus.mem_wdata}, is_d ? {16'd0, wdata} : 32'd0);
    end
    @(negedge clk);
    check("mem_we_cleared", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned c0;
    bit exp_d_g, exp_if_g;
    exp_t e;

    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h3000;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h5000; bus.d_wdata = 16'h0000;

    // Reset with both requests asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      check("rst_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
      check("rst_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
      check("rst_if_rdata", {16'd0, bus.if_rdata}, 32'd0);
      check("rst_d_rdata", {16'd0, bus.d_rdata}, 32'd0);
      check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
      @(posedge clk);
    end
    #1 reset = 1'b1;

    // Both requests held: grant sequence every 3 cycles
    c0 = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
`ifdef LC3_ARB_RR_EN
      exp_d_g  = (k == 0) || (k == 6);
      exp_if_g = (k == 3);
`else
      exp_d_g  = (k % 3 == 0);
      exp_if_g = 1'b0;
`endif
      check("tie_d_gnt", {31'd0, bus.d_gnt}, {31'd0, exp_d_g});
      check("tie_if_gnt", {31'd0, bus.if_gnt}, {31'd0, exp_if_g});
      e.cyc = c0 + k + 3;
      if (exp_d_g)  begin e.data = 16'hA5A5; q_d.push_back(e);  end
      if (exp_if_g) begin e.data = 16'h1234; q_if.push_back(e); end
      if (k < 8) @(posedge clk);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fetch, store, load-back
    do_req(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234);
    do_req(1'b1, 1'b1, 16'h4000, 16'hBEEF, 16'h0000);
    do_req(1'b1, 1'b0, 16'h4000, 16'h0000, 16'hBEEF);

    // Data request pulsed for one cycle while fetch owns the port
    bus.if_req = 1'b1; bus.if_addr = 16'h3000;
    @(negedge clk);
    check("drop_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
    e.data = 16'h1234; e.cyc = cyc + 3; q_if.push_back(e);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h7000; bus.d_wdata = 16'h1111;
    @(negedge clk);
    check("drop_d_gnt_access", {31'd0, bus.d_gnt}, 32'd0);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
      check("drop_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("drop_mem_addr", {16'd0, bus.mem_addr}, 32'h3000);
    end
    @(posedge clk); #1;

    // Reset in the middle of a store aborts it
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h6000; bus.d_wdata = 16'hCAFE;
    @(negedge clk);
    check("abort_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_we_t1", {31'd0, bus.mem_we}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h3000;
    @(negedge clk);
    check("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("abort_d_rvalid_t2", {31'd0, bus.d_rvalid}, 32'd0);
    check("abort_idle_gnt", {31'd0, bus.d_gnt}, 32'd1);
    e.data = 16'h1234; e.cyc = cyc + 3; q_d.push_back(e);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("abort_d_rvalid_t3", {31'd0, bus.d_rvalid}, 32'd0);

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("q_if_drained", q_if.size(), 32'd0);
    check("q_d_drained", q_d.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
